uart_send_char: RTL and testbench
=================================

// Module: uart_send_char
// PURPOSE
//  Transmit side of the UART monitor: turns monitor events into ASCII for the UART transmitter.
//  Sources: echo of received keystrokes, CR/LF requests from the command decoder, 32-bit words.
//  Words come from dump/PC-print logic and are printed as 8 lowercase hex digits plus a space.
//  Sits between monitor ctrl logic and the byte-level UART transmitter; one char in flight at a time.
// PARAMETERS
//  (none) -- fixed 32-bit word, 8 hex digits, 8-bit chars
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  echo_char    in   8   received character to echo
//  echo_en      in   1   1-cycle strobe: echo_char valid
//  crlf_in      in   1   1-cycle strobe: emit CR (0x0d) then LF (0x0a)
//  word_data    in   32  word to print
//  word_en      in   1   1-cycle strobe: word_data valid
//  tx_ready     in   1   transmitter can accept a char
//  tx_data      out  8   character to transmit
//  tx_en        out  1   1-cycle strobe: tx_data valid
//  word_ready   out  1   1 = word slot empty; word_en accepted this cycle
//  send_busy    out  1   1 = any request pending or char sequence in progress
//  req_drop     out  1   1-cycle pulse: a request was discarded (overrun)
// BEHAVIOUR
//  Reset: all outputs 0 except word_ready=1; pending flags, counters and FSM cleared to IDLE.
//  Reset mid-sequence abandons the current char/word; no further tx_en until a new request arrives.
//  Pending slots (one deep each): echo_pend+echo_reg, crlf_pend, word_pend+word_reg.
//   - echo_en while echo_pend=1 -> new char dropped, req_drop=1. echo_char==0x0d is never echoed (CR goes via crlf_in).
//   - crlf_in while crlf_pend=1 -> merged, no drop (one CR/LF pair).
//   - word_en while word_pend=1 -> dropped, req_drop=1; word_reg unchanged.
//   - A request and the completion of the same slot in one cycle: completion wins; new request treated as slot-full.
//  Source priority at LOAD: echo > crlf > word. Once a CRLF or word sequence starts it runs to completion;
//   echo/crlf arriving meanwhile wait in their slots.
//  FSM: IDLE -> LOAD when any pend=1. LOAD: select source, latch char into tx_data -> SEND.
//   SEND: wait tx_ready=1; then tx_en=1 for exactly one cycle -> GAP.
//   GAP: one cycle, tx_ready ignored (transmitter must drop tx_ready the cycle after tx_en) -> WAIT.
//   WAIT: wait tx_ready=1; if sequence has more chars -> LOAD (same source), else clear that pend -> IDLE.
//  Word sequence: nib_cnt 0..8; cnt 0..7 sends word_reg[31-4*cnt -: 4] as ASCII
//   (0-9 -> 0x30-0x39, a-f -> 0x61-0x66, lowercase); cnt 8 sends 0x20; word_pend clears after the space.
//  CRLF sequence: crlf_cnt 0 -> 0x0d, 1 -> 0x0a; crlf_pend clears after LF.
//  tx_data holds last char between strobes; only tx_en qualifies it.
//  Latency: idle block, tx_ready=1: request at cycle N -> tx_en at N+3 (pend reg, LOAD, SEND).
//  word_ready = ~word_pend; send_busy = (state!=IDLE) | echo_pend | crlf_pend | word_pend.
// STRUCTURE
//  Shared package uart_mon_pkg: ASCII_CR=8'h0d, ASCII_LF=8'h0a, ASCII_SP=8'h20,
//   ASCII_0=8'h30, ASCII_A=8'h61, TX state encoding (IDLE/LOAD/SEND/GAP/WAIT).
//  Sub-module nibble_to_ascii (4-bit in, 8-bit lowercase hex char out, combinational).
//  Top: pending slots, source select, nib_cnt/crlf_cnt, FSM.
// TESTING
//  1 word_en, word_data=32'h0000_12ab, tx_ready=1 -> tx chars "000012ab " (0x30x4,0x31,0x32,0x61,0x62,0x20); word_ready back to 1 after space.
//  2 echo_en 'w'(0x77) and crlf_in same cycle while idle -> 0x77, then 0x0d, 0x0a; echo_en 0x0d alone -> no tx_en.
//  3 word_en during word print, tx_ready gaps of 10 cycles -> req_drop pulse, first word printed intact, second never printed.
//  4 echo_en mid-word (after 3rd digit) -> echo char sent only after trailing 0x20; order of word digits unchanged.
//  5 tx_ready held 0 for 50 cycles after tx_en -> exactly one tx_en per char, no duplicates; tx_ready stuck 1 -> tx_en spacing >= 3 cycles.
//  6 rst asserted after 4th digit -> outputs to reset values next cycle; subsequent word_en 32'hffffffff prints "ffffffff ".

Source files
------------

// File: rtl/uart_mon_pkg.sv
// rtl/uart_mon_pkg.sv - shared ASCII constants and TX state encodings for the UART monitor
package uart_mon_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h61;

    localparam logic [3:0] NIB_LAST = 4'd8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND,
        TX_GAP,
        TX_WAIT
    } tx_state_e;

    typedef enum logic [1:0] {
        SRC_ECHO,
        SRC_CRLF,
        SRC_WORD
    } tx_src_e;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - 4-bit value to lowercase ASCII hex digit
module nibble_to_ascii
    import uart_mon_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb begin
        if (nib < 4'd10) begin
            ascii = ASCII_0 + {4'd0, nib};
        end else begin
            ascii = ASCII_A + {4'd0, nib} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_send_char.sv
// rtl/uart_send_char.sv - converts echo, CR/LF and hex-word requests into single UART chars
module uart_send_char
    import uart_mon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  echo_char,
    input  logic        echo_en,
    input  logic        crlf_in,
    input  logic [31:0] word_data,
    input  logic        word_en,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        word_ready,
    output logic        send_busy,
    output logic        req_drop
);

    tx_state_e   state_q, state_d;
    tx_src_e     src_q, src_d, load_src;
    logic        echo_pend_q, echo_pend_d;
    logic [7:0]  echo_reg_q, echo_reg_d;
    logic        crlf_pend_q, crlf_pend_d;
    logic        word_pend_q, word_pend_d;
    logic [31:0] word_reg_q, word_reg_d;
    logic [3:0]  nib_cnt_q, nib_cnt_d;
    logic        crlf_cnt_q, crlf_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        req_drop_q, req_drop_d;

    logic [31:0] word_shift;
    logic [7:0]  nib_char;
    logic        echo_req;
    logic        echo_clr, crlf_clr, word_clr;

    assign word_shift = word_reg_q << {nib_cnt_q[2:0], 2'b00};
    assign echo_req   = echo_en && (echo_char != ASCII_CR);

    nibble_to_ascii u_nib (
        .nib   (word_shift[31:28]),
        .ascii (nib_char)
    );

    // A sequence already under way keeps the transmitter until its last char.
    always_comb begin
        if (crlf_cnt_q) begin
            load_src = SRC_CRLF;
        end else if (nib_cnt_q != 4'd0) begin
            load_src = SRC_WORD;
        end else if (echo_pend_q) begin
            load_src = SRC_ECHO;
        end else if (crlf_pend_q) begin
            load_src = SRC_CRLF;
        end else begin
            load_src = SRC_WORD;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        echo_pend_d = echo_pend_q;
        echo_reg_d  = echo_reg_q;
        crlf_pend_d = crlf_pend_q;
        word_pend_d = word_pend_q;
        word_reg_d  = word_reg_q;
        nib_cnt_d   = nib_cnt_q;
        crlf_cnt_d  = crlf_cnt_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        req_drop_d  = 1'b0;
        echo_clr    = 1'b0;
        crlf_clr    = 1'b0;
        word_clr    = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (echo_pend_q || crlf_pend_q || word_pend_q) begin
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                src_d   = load_src;
                state_d = TX_SEND;
                case (load_src)
                    SRC_ECHO: tx_data_d = echo_reg_q;
                    SRC_CRLF: tx_data_d = crlf_cnt_q ? ASCII_LF : ASCII_CR;
                    default:  tx_data_d = (nib_cnt_q == NIB_LAST) ? ASCII_SP : nib_char;
                endcase
            end
            TX_SEND: begin
                if (tx_ready) begin
                    tx_en_d = 1'b1;
                    state_d = TX_GAP;
                end
            end
            TX_GAP: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_ready) begin
                    state_d = TX_IDLE;
                    case (src_q)
                        SRC_ECHO: echo_clr = 1'b1;
                        SRC_CRLF: begin
                            if (!crlf_cnt_q) begin
                                crlf_cnt_d = 1'b1;
                                state_d    = TX_LOAD;
                            end else begin
                                crlf_cnt_d = 1'b0;
                                crlf_clr   = 1'b1;
                            end
                        end
                        default: begin
                            if (nib_cnt_q == NIB_LAST) begin
                                nib_cnt_d = 4'd0;
                                word_clr  = 1'b1;
                            end else begin
                                nib_cnt_d = nib_cnt_q + 4'd1;
                                state_d   = TX_LOAD;
                            end
                        end
                    endcase
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Slot-full test uses the registered flag, so a request colliding with completion is refused.
        if (echo_req) begin
            if (echo_pend_q) begin
                req_drop_d = 1'b1;
            end else begin
                echo_pend_d = 1'b1;
                echo_reg_d  = echo_char;
            end
        end
        if (echo_clr) echo_pend_d = 1'b0;

        if (crlf_in && !crlf_pend_q) crlf_pend_d = 1'b1;
        if (crlf_clr) crlf_pend_d = 1'b0;

        if (word_en) begin
            if (word_pend_q) begin
                req_drop_d = 1'b1;
            end else begin
                word_pend_d = 1'b1;
                word_reg_d  = word_data;
            end
        end
        if (word_clr) word_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            src_q       <= SRC_ECHO;
            echo_pend_q <= 1'b0;
            echo_reg_q  <= 8'd0;
            crlf_pend_q <= 1'b0;
            word_pend_q <= 1'b0;
            word_reg_q  <= 32'd0;
            nib_cnt_q   <= 4'd0;
            crlf_cnt_q  <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_en_q     <= 1'b0;
            req_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            echo_pend_q <= echo_pend_d;
            echo_reg_q  <= echo_reg_d;
            crlf_pend_q <= crlf_pend_d;
            word_pend_q <= word_pend_d;
            word_reg_q  <= word_reg_d;
            nib_cnt_q   <= nib_cnt_d;
            crlf_cnt_q  <= crlf_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            req_drop_q  <= req_drop_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_en      = tx_en_q;
    assign req_drop   = req_drop_q;
    assign word_ready = ~word_pend_q;
    assign send_busy  = (state_q != TX_IDLE) | echo_pend_q | crlf_pend_q | word_pend_q;

endmodule

// File: tb/tb_uart_send_char.sv
// tb/tb_uart_send_char.sv - directed self-checking bench for uart_send_char
module tb_uart_send_char;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  echo_char = 8'd0;
    logic        echo_en = 1'b0;
    logic        crlf_in = 1'b0;
    logic [31:0] word_data = 32'd0;
    logic        word_en = 1'b0;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        word_ready;
    logic        send_busy;
    logic        req_drop;

    logic        gap_mode = 1'b0;
    logic        manual_ready = 1'b1;
    logic        auto_ready = 1'b1;
    int          gap_len = 10;
    int          gap_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          drop_cnt = 0;
    logic [7:0]  txq[$];
    int          tcyc[$];

    assign tx_ready = gap_mode ? auto_ready : manual_ready;

    uart_send_char dut (
        .clk        (clk),
        .rst        (rst),
        .echo_char  (echo_char),
        .echo_en    (echo_en),
        .crlf_in    (crlf_in),
        .word_data  (word_data),
        .word_en    (word_en),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .word_ready (word_ready),
        .send_busy  (send_busy),
        .req_drop   (req_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (tx_en === 1'b1) begin
            txq.push_back(tx_data);
            tcyc.push_back(cyc);
        end
        if (req_drop === 1'b1) drop_cnt = drop_cnt + 1;
    end

    // Transmitter model: busy for gap_len cycles after each accepted char.
    always @(negedge clk) begin
        if (gap_mode) begin
            if (tx_en === 1'b1) begin
                auto_ready = 1'b0;
                gap_cnt    = gap_len;
            end else if (gap_cnt > 0) begin
                gap_cnt = gap_cnt - 1;
                if (gap_cnt == 0) auto_ready = 1'b1;
            end
        end
    end

    task automatic pulse_word(input logic [31:0] d);
        @(negedge clk);
        word_data = d;
        word_en   = 1'b1;
        @(negedge clk);
        word_en   = 1'b0;
    endtask

    task automatic pulse_echo(input logic [7:0] c, input logic with_crlf);
        @(negedge clk);
        echo_char = c;
        echo_en   = 1'b1;
        crlf_in   = with_crlf;
        @(negedge clk);
        echo_en   = 1'b0;
        crlf_in   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (send_busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (send_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: send_busy=%b after %0d cycles, required 0", send_busy, n);
        end
    endtask

    task automatic wait_txq(input int count, input int max_cyc);
        int n = 0;
        while (txq.size() < count && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txq.size() < count) begin
            errors++;
            $display("FAIL txq_timeout: got %0d chars, required %0d", txq.size(), count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_en !== 1'b0)       begin errors++; $display("FAIL rst_tx_en: got %b, required 0", tx_en); end
        checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL rst_tx_data: got %h, required 00", tx_data); end
        checks++; if (word_ready !== 1'b1)  begin errors++; $display("FAIL rst_word_ready: got %b, required 1", word_ready); end
        checks++; if (send_busy !== 1'b0)   begin errors++; $display("FAIL rst_send_busy: got %b, required 0", send_busy); end
        checks++; if (req_drop !== 1'b0)    begin errors++; $display("FAIL rst_req_drop: got %b, required 0", req_drop); end
    endtask

    task automatic test_word();
        string s = "000012ab ";
        int    req_cyc;
        txq.delete(); tcyc.delete();
        manual_ready = 1'b1;
        pulse_word(32'h0000_12ab);
        req_cyc = cyc;
        checks++; if (word_ready !== 1'b0) begin errors++; $display("FAIL word_ready_busy: got %b, required 0", word_ready); end
        wait_idle(200);
        checks++;
        if (txq.size() != s.len()) begin errors++; $display("FAIL word_len: got %0d, required %0d", txq.size(), s.len()); end
        for (int i = 0; i < s.len() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL word_char%0d: got %h, required %h", i, txq[i], s[i]); end
        end
        if (tcyc.size() > 0) begin
            checks++;
            if (tcyc[0] != req_cyc + 3) begin errors++; $display("FAIL word_latency: got %0d, required %0d", tcyc[0] - req_cyc, 3); end
        end
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL word_ready_after: got %b, required 1", word_ready); end
    endtask

    task automatic test_echo_crlf();
        string s = "w\r\n";
        txq.delete(); tcyc.delete();
        pulse_echo(8'h77, 1'b1);
        wait_idle(200);
        checks++;
        if (txq.size() != s.len()) begin errors++; $display("FAIL echo_crlf_len: got %0d, required %0d", txq.size(), s.len()); end
        for (int i = 0; i < s.len() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL echo_crlf_char%0d: got %h, required %h", i, txq[i], s[i]); end
        end
        txq.delete();
        pulse_echo(8'h0d, 1'b0);
        checks++; if (send_busy !== 1'b0) begin errors++; $display("FAIL echo_cr_busy: got %b, required 0", send_busy); end
        repeat (10) @(negedge clk);
        checks++; if (txq.size() != 0) begin errors++; $display("FAIL echo_cr_sent: got %0d chars, required 0", txq.size()); end
    endtask

    task automatic test_drop();
        string s = "89abcdef ";
        int    d0;
        txq.delete(); tcyc.delete();
        auto_ready = 1'b1;
        gap_cnt    = 0;
        gap_mode   = 1'b1;
        d0 = drop_cnt;
        pulse_word(32'h89ab_cdef);
        wait_txq(2, 100);
        pulse_word(32'h1111_1111);
        wait_idle(500);
        gap_mode = 1'b0;
        checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL drop_count: got %0d, required 1", drop_cnt - d0); end
        checks++;
        if (txq.size() != s.len()) begin errors++; $display("FAIL drop_len: got %0d, required %0d", txq.size(), s.len()); end
        for (int i = 0; i < s.len() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL drop_char%0d: got %h, required %h", i, txq[i], s[i]); end
        end
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL drop_word_ready: got %b, required 1", word_ready); end
    endtask

    task automatic test_echo_mid_word();
        string s = "deadbeef A";
        txq.delete(); tcyc.delete();
        manual_ready = 1'b1;
        pulse_word(32'hdead_beef);
        wait_txq(3, 100);
        pulse_echo(8'h41, 1'b0);
        wait_idle(300);
        checks++;
        if (txq.size() != s.len()) begin errors++; $display("FAIL mid_len: got %0d, required %0d", txq.size(), s.len()); end
        for (int i = 0; i < s.len() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL mid_char%0d: got %h, required %h", i, txq[i], s[i]); end
        end
    endtask

    task automatic test_ready_hold();
        string s = "\r\n";
        txq.delete(); tcyc.delete();
        manual_ready = 1'b1;
        @(negedge clk);
        crlf_in = 1'b1;
        @(negedge clk);
        crlf_in = 1'b0;
        wait_txq(1, 50);
        manual_ready = 1'b0;
        repeat (50) @(negedge clk);
        checks++; if (txq.size() != 1) begin errors++; $display("FAIL hold_count: got %0d chars, required 1", txq.size()); end
        checks++; if (send_busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b, required 1", send_busy); end
        manual_ready = 1'b1;
        wait_idle(100);
        checks++;
        if (txq.size() != s.len()) begin errors++; $display("FAIL hold_len: got %0d, required %0d", txq.size(), s.len()); end
        for (int i = 0; i < s.len() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL hold_char%0d: got %h, required %h", i, txq[i], s[i]); end
        end
        txq.delete(); tcyc.delete();
        pulse_word(32'h0000_0000);
        wait_idle(200);
        checks++; if (txq.size() != 9) begin errors++; $display("FAIL stuck_len: got %0d, required 9", txq.size()); end
        for (int i = 1; i < tcyc.size(); i++) begin
            checks++;
            if (tcyc[i] - tcyc[i-1] < 3) begin errors++; $display("FAIL stuck_spacing%0d: got %0d, required >=3", i, tcyc[i] - tcyc[i-1]); end
        end
    endtask

    task automatic test_reset_mid();
        string s = "ffffffff ";
        txq.delete(); tcyc.delete();
        manual_ready = 1'b1;
        pulse_word(32'h1234_5678);
        wait_txq(4, 100);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_en !== 1'b0)      begin errors++; $display("FAIL midrst_tx_en: got %b, required 0", tx_en); end
        checks++; if (tx_data !== 8'h00)   begin errors++; $display("FAIL midrst_tx_data: got %h, required 00", tx_data); end
        checks++; if (word_ready !== 1'b1) begin errors++; $display("FAIL midrst_word_ready: got %b, required 1", word_ready); end
        checks++; if (send_busy !== 1'b0)  begin errors++; $display("FAIL midrst_send_busy: got %b, required 0", send_busy); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (txq.size() != 4) begin errors++; $display("FAIL midrst_extra_tx: got %0d chars, required 4", txq.size()); end
        txq.delete(); tcyc.delete();
        pulse_word(32'hffff_ffff);
        wait_idle(200);
        checks++;
        if (txq.size() != s.len()) begin errors++; $display("FAIL ff_len: got %0d, required %0d", txq.size(), s.len()); end
        for (int i = 0; i < s.len() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL ff_char%0d: got %h, required %h", i, txq[i], s[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_echo_crlf();
        test_drop();
        test_echo_mid_word();
        test_ready_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
